// File: rtl/demod_sample_ctrl.sv
// ---------------------------------------------------------------------------
// demod_sample_ctrl
//   Sequencer for the IQ demodulation datapath. Divides the system clock into
//   the ADC sample strobe and steps an fs/4 quadrature LO (cosine/sine) in
//   lock-step with it. Keeps count of samples in flight through the
//   demodulator using its demod_rdy return. Raises sticky overrun, spurious
//   and drain-timeout error flags.
//
// Ports
//   clk          in   1      system clock
//   resetn       in   1      asynchronous active-low reset
//   enable       in   1      level: 1 = run sampling, 0 = stop and drain
//   err_clr      in   1      pulse, clears the sticky error flags
//   demod_rdy    in   1      pulse from the demodulator, one per processed sample
//   ADC_rdy      out  1      one-cycle sample strobe
//   cosine_out   out  2      LO cosine, two's complement (01=+1, 00=0, 11=-1)
//   sine_out     out  2      LO sine, same encoding
//   busy         out  1      high in any state other than IDLE
//   sample_cnt   out  CNT_W  strobes issued since the last ARM, wraps
//   outstanding  out  2      samples issued but not yet returned
//   err_overrun  out  1      sticky: strobe issued with outstanding at MAX_OUTST
//   err_spurious out  1      sticky: demod_rdy with nothing outstanding
//   err_timeout  out  1      sticky: DRAIN expired with samples still outstanding
//
// State  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | stopped, LO parked at phase 0, waiting for enable
// ARM    | single cycle: clears divider, phase, sample count, outstanding
// RUN    | divider running, one ADC_rdy every CLK_DIV clocks
// DRAIN  | no strobes; waits for outstanding samples, bounded by DRAIN_TO
// ---------------------------------------------------------------------------
module demod_sample_ctrl #(
  parameter int CLK_DIV   = 5,
  parameter int MAX_OUTST = 2,
  parameter int DRAIN_TO  = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             err_clr,
  input  logic             demod_rdy,
  output logic             ADC_rdy,
  output logic [1:0]       cosine_out,
  output logic [1:0]       sine_out,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [1:0]       outstanding,
  output logic             err_overrun,
  output logic             err_spurious,
  output logic             err_timeout
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMR_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TO - 1);
  localparam logic [1:0]       OUTST_MAX  = 2'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [TMR_W-1:0]  r_drain_tmr;
  logic [1:0]        r_phase;
  logic [1:0]        r_cos;
  logic [1:0]        r_sin;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [1:0]        r_outst;
  logic              r_err_ovr;
  logic              r_err_spur;
  logic              r_err_to;

  logic              w_adc_rdy;
  logic [1:0]        w_outst_nxt;
  logic              w_ovr_evt;
  logic              w_spur_evt;
  logic              w_to_evt;

  // LO lookup: {cos, sin} for each quarter of the fs/4 cycle.
  function automatic logic [3:0] lo_of(input logic [1:0] ph);
    logic [3:0] v;
    case (ph)
      2'd0:    v = {2'b01, 2'b00};
      2'd1:    v = {2'b00, 2'b11};
      2'd2:    v = {2'b11, 2'b00};
      default: v = {2'b00, 2'b01};
    endcase
    return v;
  endfunction

  // The strobe is gated by the live enable so that the last RUN cycle (the one
  // in which enable is seen low) never issues a sample that DRAIN would then
  // have to wait for.
  assign w_adc_rdy = (r_state == S_RUN) && enable && (r_div_cnt == DIV_LAST);

  // In-flight bookkeeping. A strobe and a return in the same cycle cancel.
  always_comb begin
    w_outst_nxt = r_outst;
    w_ovr_evt   = 1'b0;
    w_spur_evt  = 1'b0;
    case ({w_adc_rdy, demod_rdy})
      2'b10: begin
        if (r_outst == OUTST_MAX) w_ovr_evt = 1'b1;
        else                      w_outst_nxt = r_outst + 2'd1;
      end
      2'b01: begin
        if (r_outst == 2'd0) w_spur_evt = 1'b1;
        else                 w_outst_nxt = r_outst - 2'd1;
      end
      default: ;
    endcase
  end

  assign w_to_evt = (r_state == S_DRAIN) && (r_outst != 2'd0) &&
                    (r_drain_tmr == DRAIN_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_drain_tmr  <= '0;
      r_phase      <= 2'd0;
      r_cos        <= 2'b01;
      r_sin        <= 2'b00;
      r_sample_cnt <= '0;
      r_outst      <= 2'd0;
      r_err_ovr    <= 1'b0;
      r_err_spur   <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      // Sticky flags: a new event wins over a simultaneous clear.
      r_err_ovr  <= w_ovr_evt  | (r_err_ovr  & ~err_clr);
      r_err_spur <= w_spur_evt | (r_err_spur & ~err_clr);
      r_err_to   <= w_to_evt   | (r_err_to   & ~err_clr);

      r_outst <= w_outst_nxt;

      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_ARM;
        end

        S_ARM: begin
          r_div_cnt    <= '0;
          r_phase      <= 2'd0;
          r_cos        <= 2'b01;
          r_sin        <= 2'b00;
          r_sample_cnt <= '0;
          r_outst      <= 2'd0;
          r_state      <= enable ? S_RUN : S_IDLE;
        end

        S_RUN: begin
          if (!enable) begin
            r_state     <= S_DRAIN;
            r_drain_tmr <= '0;
          end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
            // LO steps after the strobe so it is steady across the whole
            // sample period, strobe cycle included.
            if (w_adc_rdy) begin
              r_phase        <= r_phase + 2'd1;
              {r_cos, r_sin} <= lo_of(r_phase + 2'd1);
              r_sample_cnt   <= r_sample_cnt + CNT_W'(1);
            end
          end
        end

        S_DRAIN: begin
          if (r_outst == 2'd0 || w_to_evt) begin
            r_state <= S_IDLE;
            r_phase <= 2'd0;
            r_cos   <= 2'b01;
            r_sin   <= 2'b00;
            if (w_to_evt) r_outst <= 2'd0;
          end else begin
            r_drain_tmr <= r_drain_tmr + TMR_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ADC_rdy      = w_adc_rdy;
  assign cosine_out   = r_cos;
  assign sine_out     = r_sin;
  assign busy         = (r_state != S_IDLE);
  assign sample_cnt   = r_sample_cnt;
  assign outstanding  = r_outst;
  assign err_overrun  = r_err_ovr;
  assign err_spurious = r_err_spur;
  assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_demod_sample_ctrl.sv
module tb_demod_sample_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        resetn, enable, err_clr, demod_rdy;
  logic        adc_rdy, busy, e_ovr, e_spur, e_to;
  logic [1:0]  cos_o, sin_o, outst;
  logic [15:0] cnt;

  // Second instance with a short divider and narrow counter for the wrap check.
  logic        enable_w, err_clr_w, demod_w;
  logic        adc_w, busy_w, e_ovr_w, e_spur_w, e_to_w;
  logic [1:0]  cos_w, sin_w, outst_w;
  logic [3:0]  cnt_w;

  demod_sample_ctrl u_dut (
    .clk(clk), .resetn(resetn), .enable(enable), .err_clr(err_clr),
    .demod_rdy(demod_rdy), .ADC_rdy(adc_rdy), .cosine_out(cos_o),
    .sine_out(sin_o), .busy(busy), .sample_cnt(cnt), .outstanding(outst),
    .err_overrun(e_ovr), .err_spurious(e_spur), .err_timeout(e_to)
  );

  demod_sample_ctrl #(.CLK_DIV(2), .MAX_OUTST(2), .DRAIN_TO(64), .CNT_W(4)) u_dut_w (
    .clk(clk), .resetn(resetn), .enable(enable_w), .err_clr(err_clr_w),
    .demod_rdy(demod_w), .ADC_rdy(adc_w), .cosine_out(cos_w),
    .sine_out(sin_w), .busy(busy_w), .sample_cnt(cnt_w), .outstanding(outst_w),
    .err_overrun(e_ovr_w), .err_spurious(e_spur_w), .err_timeout(e_to_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] cos_tab [4] = '{2'b01, 2'b00, 2'b11, 2'b00};
  logic [1:0] sin_tab [4] = '{2'b00, 2'b11, 2'b00, 2'b01};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    enable    = 1'b0;
    err_clr   = 1'b0;
    demod_rdy = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_adc, exp_ph, exp_out, n_busy, adc_seen;
    resetn = 1'b0; enable = 1'b0; err_clr = 1'b0; demod_rdy = 1'b0;
    enable_w = 1'b0; err_clr_w = 1'b0; demod_w = 1'b0;
    @(negedge clk);

    // Reset state
    check_val("rst_adc",  adc_rdy, 0);
    check_val("rst_cos",  cos_o, 2'b01);
    check_val("rst_sin",  sin_o, 2'b00);
    check_val("rst_busy", busy, 0);
    check_val("rst_cnt",  cnt, 0);
    check_val("rst_out",  outst, 0);
    check_val("rst_err",  {e_ovr, e_spur, e_to}, 0);
    resetn = 1'b1;
    tick();

    // T1: continuous run with demod_rdy echoed one cycle after each strobe
    enable = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      tick();
      demod_rdy = (c >= 7 && (c - 7) % 5 == 0);
      exp_adc   = (c >= 6 && (c - 6) % 5 == 0) ? 1 : 0;
      exp_ph    = (c <= 6) ? 0 : (((c - 7) / 5) + 1) % 4;
      exp_out   = (c >= 7 && (c - 7) % 5 == 0) ? 1 : 0;
      check_val("t1_adc", adc_rdy, exp_adc);
      check_val("t1_cos", cos_o, cos_tab[exp_ph]);
      check_val("t1_sin", sin_o, sin_tab[exp_ph]);
      check_val("t1_out", outst, exp_out);
      check_val("t1_busy", busy, 1);
    end
    demod_rdy = 1'b0;
    check_val("t1_cnt", cnt, 8);
    check_val("t1_err", {e_ovr, e_spur, e_to}, 0);

    // T2: no returns -> overrun on the third strobe, clear, set-wins
    do_reset();
    enable = 1'b1;
    repeat (7) tick();
    check_val("t2_out1", outst, 1);
    repeat (5) tick();
    check_val("t2_out2", outst, 2);
    check_val("t2_ovr_pre", e_ovr, 0);
    repeat (4) tick();
    check_val("t2_adc3", adc_rdy, 1);
    check_val("t2_ovr_at3", e_ovr, 0);
    tick();
    check_val("t2_out_sat", outst, 2);
    check_val("t2_ovr_set", e_ovr, 1);
    check_val("t2_cnt", cnt, 3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("t2_ovr_clr", e_ovr, 0);
    repeat (3) tick();
    check_val("t2_adc4", adc_rdy, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("t2_set_wins", e_ovr, 1);

    // T3: demod_rdy while IDLE
    do_reset();
    demod_rdy = 1'b1;
    tick();
    demod_rdy = 1'b0;
    check_val("t3_spur", e_spur, 1);
    check_val("t3_out", outst, 0);
    check_val("t3_busy", busy, 0);

    // T4: strobe and return coincide with one outstanding
    do_reset();
    enable = 1'b1;
    repeat (7) tick();
    check_val("t4_out_pre", outst, 1);
    repeat (4) tick();
    check_val("t4_adc", adc_rdy, 1);
    demod_rdy = 1'b1;
    tick();
    demod_rdy = 1'b0;
    check_val("t4_out", outst, 1);
    check_val("t4_err", {e_ovr, e_spur, e_to}, 0);

    // T5a: enable drops with one outstanding and no return -> timeout
    do_reset();
    enable = 1'b1;
    repeat (7) tick();
    check_val("t5a_out_pre", outst, 1);
    enable = 1'b0;
    n_busy = 0;
    adc_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (adc_rdy) adc_seen = 1;
      if (!busy) break;
      n_busy++;
    end
    check_val("t5a_busy_clks", n_busy, 64);
    check_val("t5a_no_adc", adc_seen, 0);
    check_val("t5a_to", e_to, 1);
    check_val("t5a_out", outst, 0);
    check_val("t5a_cos", cos_o, 2'b01);
    check_val("t5a_sin", sin_o, 2'b00);

    // T5b: return arrives three clocks after enable drops
    do_reset();
    enable = 1'b1;
    repeat (7) tick();
    enable = 1'b0;
    repeat (3) tick();
    check_val("t5b_busy_wait", busy, 1);
    demod_rdy = 1'b1;
    tick();
    demod_rdy = 1'b0;
    check_val("t5b_out", outst, 0);
    check_val("t5b_busy_last", busy, 1);
    tick();
    check_val("t5b_idle", busy, 0);
    check_val("t5b_err", {e_ovr, e_spur, e_to}, 0);

    // T6: asynchronous reset mid-RUN at phase 2
    do_reset();
    enable = 1'b1;
    repeat (13) tick();
    check_val("t6_cos_pre", cos_o, 2'b11);
    check_val("t6_out_pre", outst, 2);
    check_val("t6_cnt_pre", cnt, 2);
    #1;
    resetn = 1'b0;
    #1;
    check_val("t6_busy", busy, 0);
    check_val("t6_cos", cos_o, 2'b01);
    check_val("t6_sin", sin_o, 2'b00);
    check_val("t6_cnt", cnt, 0);
    check_val("t6_out", outst, 0);
    check_val("t6_adc", adc_rdy, 0);
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Counter wrap on the narrow instance: strobe k lands in cycle 1+2k
    enable_w = 1'b1;
    repeat (32) tick();
    check_val("wrap_cnt15", cnt_w, 15);
    repeat (2) tick();
    check_val("wrap_cnt0", cnt_w, 0);
    enable_w = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
